pipe_stage_skid: RTL

- Parametrised inter-stage pipeline register, the generic successor to the fixed-field EX/MEM latch.
- Carries an opaque packed payload with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
- With the skid buffer, upstream ready is registered, which breaks the backward timing path. This lets EX->MEM, MEM->WB and similar boundaries stall and flush without combinational ready chains.
- Also counts back-pressure cycles for performance analysis.

---
 rtl/pipe_stage_skid_if.sv | 21 ++
 rtl/pipe_stage_skid.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Single valid/ready/data channel between two pipeline stages.
// The master drives valid and data; the slave drives ready.
interface pipe_stage_skid_if #(
   parameter int unsigned PAYLOAD_W = 32
);
   logic                 valid;
   logic                 ready;
   logic [PAYLOAD_W-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer (registered upstream ready) and a saturating stall counter.
module pipe_stage_skid #(
   parameter int unsigned           PAYLOAD_W   = 32,
   parameter logic [PAYLOAD_W-1:0]  NOP_PAYLOAD = '0,
   parameter bit                    SKID_EN     = 1'b1,
   parameter int unsigned           CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   pipe_stage_skid_if.slave  in_if,
   pipe_stage_skid_if.master out_if,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      StEmpty,
      StBusy,
      StFull
   } state_e;

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_e               state_q;
   logic [PAYLOAD_W-1:0] main_q;
   logic [PAYLOAD_W-1:0] skid_q;
   logic                 in_ready_q;
   logic [1:0]           occ_q;
   logic [CNT_W-1:0]     stall_q;

   logic out_valid;
   logic in_ready;
   logic in_fire;
   logic out_fire;

   // Handshake decode; with the skid buffer in_ready comes straight from a flop so there is
   // no combinational path from out_ready back upstream.
   always_comb begin
      out_valid = (state_q != StEmpty);
      in_ready  = SKID_EN ? in_ready_q : (!out_valid || out_if.ready);
      in_fire   = in_if.valid && in_ready;
      out_fire  = out_valid && out_if.ready;
   end

   assign in_if.ready  = in_ready;
   assign out_if.valid = out_valid;
   assign out_if.data  = main_q;
   assign occupancy_o  = occ_q;
   assign stall_cnt_o  = stall_q;

   // Entry state machine; main_q is kept at NOP_PAYLOAD whenever nothing is held so that
   // out_data needs no output mux.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         // A flush drops everything held; an out_fire in the same cycle has already completed.
         state_q    <= StEmpty;
         main_q     <= NOP_PAYLOAD;
         skid_q     <= NOP_PAYLOAD;
         in_ready_q <= 1'b1;
         occ_q      <= 2'd0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  state_q <= StBusy;
                  main_q  <= in_if.data;
                  occ_q   <= 2'd1;
               end
            end
            StBusy: begin
               if (in_fire && out_fire) begin
                  main_q <= in_if.data;
               end else if (in_fire) begin
                  if (SKID_EN) begin
                     // Downstream stalled: park the new entry behind the head.
                     state_q    <= StFull;
                     skid_q     <= in_if.data;
                     in_ready_q <= 1'b0;
                     occ_q      <= 2'd2;
                  end else begin
                     main_q <= in_if.data;
                  end
               end else if (out_fire) begin
                  state_q <= StEmpty;
                  main_q  <= NOP_PAYLOAD;
                  occ_q   <= 2'd0;
               end
            end
            StFull: begin
               // Upstream is blocked here, so only the drain matters.
               if (out_fire) begin
                  state_q    <= StBusy;
                  main_q     <= skid_q;
                  skid_q     <= NOP_PAYLOAD;
                  in_ready_q <= 1'b1;
                  occ_q      <= 2'd1;
               end
            end
            default: begin
               state_q    <= StEmpty;
               main_q     <= NOP_PAYLOAD;
               skid_q     <= NOP_PAYLOAD;
               in_ready_q <= 1'b1;
               occ_q      <= 2'd0;
            end
         endcase
      end
   end

   // Back-pressure counter: saturates instead of wrapping, survives flush.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (out_valid && !out_if.ready && (stall_q != CntMax)) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

endmodule
